// File: rtl/branch_hazard_ctrl_if.sv
// rtl/branch_hazard_ctrl_if.sv - ID-stage hazard/branch control bundle between pipeline and controller
interface branch_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_is_branch;
    logic             id_is_jump;
    logic             br_eq;
    logic [4:0]       ID_EX_rd;
    logic             ID_EX_reg_write;
    logic             ID_EX_mem_read;
    logic [4:0]       EX_MEM_rd;
    logic             EX_MEM_reg_write;
    logic             clr_cnt;

    logic             pc_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             pc_sel;
    logic             ctrl_sel;
    logic [1:0]       forward_comp1;
    logic [1:0]       forward_comp2;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: presents stage state, consumes the control decisions.
    modport master (
        output IF_ID_rs1, IF_ID_rs2, id_uses_rs1, id_uses_rs2, id_is_branch,
               id_is_jump, br_eq, ID_EX_rd, ID_EX_reg_write, ID_EX_mem_read,
               EX_MEM_rd, EX_MEM_reg_write, clr_cnt,
        input  pc_write, IF_ID_write, IF_ID_flush, pc_sel, ctrl_sel,
               forward_comp1, forward_comp2, stall_cnt, flush_cnt
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, id_uses_rs1, id_uses_rs2, id_is_branch,
               id_is_jump, br_eq, ID_EX_rd, ID_EX_reg_write, ID_EX_mem_read,
               EX_MEM_rd, EX_MEM_reg_write, clr_cnt,
        output pc_write, IF_ID_write, IF_ID_flush, pc_sel, ctrl_sel,
               forward_comp1, forward_comp2, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - load-use stall sequencing, branch redirect and ID comparator forwarding
module branch_hazard_ctrl #(
    parameter int BR_LOAD_STALLS = 2,
    parameter int CNT_W          = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    branch_hazard_ctrl_if.slave hz
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0]       BR_REM  = 2'(BR_LOAD_STALLS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic m1, m2, load_use, taken;
    logic stall_cyc, redirect;

    // EX wins over MEM; a load in EX cannot forward since its data is not ready yet.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] ex_rd,
        input logic       ex_wr,
        input logic       ex_ld,
        input logic [4:0] mem_rd,
        input logic       mem_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_wr && !ex_ld && (ex_rd != 5'd0) && (ex_rd == rs)) begin
            sel = 2'b01;
        end else if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        m1 = hz.id_uses_rs1 && (hz.IF_ID_rs1 != 5'd0) && (hz.IF_ID_rs1 == hz.ID_EX_rd);
        m2 = hz.id_uses_rs2 && (hz.IF_ID_rs2 != 5'd0) && (hz.IF_ID_rs2 == hz.ID_EX_rd);
        load_use = hz.ID_EX_mem_read && (m1 || m2);
        taken    = (hz.id_is_branch && hz.br_eq) || hz.id_is_jump;

        stall_cyc = reset_n && ((state_q == STALL) || load_use);
        redirect  = reset_n && (state_q == RUN) && !load_use && taken;
    end

    always_comb begin
        hz.pc_write    = reset_n && !stall_cyc;
        hz.IF_ID_write = reset_n && !stall_cyc;
        hz.ctrl_sel    = reset_n && !stall_cyc;
        hz.pc_sel      = redirect;
        hz.IF_ID_flush = redirect;
        hz.forward_comp1 = 2'b00;
        hz.forward_comp2 = 2'b00;
        if (reset_n) begin
            hz.forward_comp1 = fwd_sel(hz.IF_ID_rs1, hz.ID_EX_rd, hz.ID_EX_reg_write,
                                       hz.ID_EX_mem_read, hz.EX_MEM_rd, hz.EX_MEM_reg_write);
            hz.forward_comp2 = fwd_sel(hz.IF_ID_rs2, hz.ID_EX_rd, hz.ID_EX_reg_write,
                                       hz.ID_EX_mem_read, hz.EX_MEM_rd, hz.EX_MEM_reg_write);
        end
        hz.stall_cnt = stall_cnt_q;
        hz.flush_cnt = flush_cnt_q;
    end

    // Only a branch waiting on a load needs more than the single RUN-state stall.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            RUN: begin
                if (load_use && hz.id_is_branch && (BR_LOAD_STALLS > 1)) begin
                    state_d = STALL;
                    rem_d   = BR_REM;
                end
            end
            STALL: begin
                rem_d = rem_q - 2'd1;
                if (rem_q == 2'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                rem_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_cyc && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (redirect && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - randomized and directed checks of branch_hazard_ctrl against a cycle model
module tb_branch_hazard_ctrl;

    localparam int CW   = 6;
    localparam int BR   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    branch_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    branch_hazard_ctrl #(.BR_LOAD_STALLS(BR), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int       extra_stalls = 0;
    int       m_stall = 0;
    int       m_flush = 0;
    logic [8:0] exp_o;
    bit       exp_stall;
    bit       exp_redirect;
    bit       arm_branch_stall;

    function automatic logic [8:0] dut_o();
        return {hz.pc_write, hz.IF_ID_write, hz.IF_ID_flush, hz.pc_sel, hz.ctrl_sel,
                hz.forward_comp1, hz.forward_comp2};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (hz.ID_EX_reg_write && !hz.ID_EX_mem_read && hz.ID_EX_rd != 0 && hz.ID_EX_rd == rs)
            return 2'b01;
        if (hz.EX_MEM_reg_write && hz.EX_MEM_rd != 0 && hz.EX_MEM_rd == rs)
            return 2'b10;
        return 2'b00;
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                         input bit br, input bit jp, input bit eq,
                         input logic [4:0] exrd, input bit exw, input bit exm,
                         input logic [4:0] memrd, input bit memw, input bit clr);
        hz.IF_ID_rs1 = rs1;       hz.IF_ID_rs2 = rs2;
        hz.id_uses_rs1 = u1;      hz.id_uses_rs2 = u2;
        hz.id_is_branch = br;     hz.id_is_jump = jp;     hz.br_eq = eq;
        hz.ID_EX_rd = exrd;       hz.ID_EX_reg_write = exw; hz.ID_EX_mem_read = exm;
        hz.EX_MEM_rd = memrd;     hz.EX_MEM_reg_write = memw;
        hz.clr_cnt = clr;
    endtask

    // Wait to mid-cycle and predict this cycle's outputs from the rules.
    task automatic settle();
        bit hazard, tk, go;
        @(negedge clk);
        hazard = hz.ID_EX_mem_read &&
                 ((hz.id_uses_rs1 && hz.IF_ID_rs1 != 0 && hz.IF_ID_rs1 == hz.ID_EX_rd) ||
                  (hz.id_uses_rs2 && hz.IF_ID_rs2 != 0 && hz.IF_ID_rs2 == hz.ID_EX_rd));
        tk = (hz.id_is_branch && hz.br_eq) || hz.id_is_jump;
        if (!reset_n) begin
            exp_o = '0; exp_stall = 0; exp_redirect = 0; arm_branch_stall = 0;
        end else begin
            exp_stall        = (extra_stalls > 0) || hazard;
            exp_redirect     = !exp_stall && tk;
            arm_branch_stall = (extra_stalls == 0) && hazard && hz.id_is_branch;
            go               = !exp_stall;
            exp_o = {go, go, exp_redirect, exp_redirect, go,
                     ref_fwd(hz.IF_ID_rs1), ref_fwd(hz.IF_ID_rs2)};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            extra_stalls = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (extra_stalls > 0) extra_stalls--;
            else if (arm_branch_stall) extra_stalls = BR - 1;
            if (hz.clr_cnt) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (exp_stall && m_stall < MAXC) m_stall++;
                if (exp_redirect && m_flush < MAXC) m_flush++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(5, 5, 1, 1, 1, 1, 1, 5, 1, 1, 5, 1, 0);
        settle();
        checks++;
        if (dut_o() !== 9'b0) begin
            errors++; $display("FAIL reset_outs got=%b want=%b", dut_o(), 9'b0);
        end
        checks++;
        if (hz.stall_cnt !== 0 || hz.flush_cnt !== 0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", hz.stall_cnt, hz.flush_cnt);
        end
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        settle();
        checks++;
        if (dut_o() !== 9'b11001_0000) begin
            errors++; $display("FAIL reset_release got=%b want=%b", dut_o(), 9'b11001_0000);
        end
        tick();
    endtask

    task automatic test_alu_forward();
        drive(5, 3, 1, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        settle();
        checks++;
        if (dut_o() !== exp_o || exp_o !== 9'b11001_0100) begin
            errors++; $display("FAIL alu_fwd got=%b want=%b", dut_o(), exp_o);
        end
        tick();
    endtask

    // Table-driven cycles: {rs1,rs2,u1,u2,br,jp,eq,exrd,exw,exm,memrd,memw,clr}
    task automatic run_table(input string name, input logic [32:0] tbl [], input bit pulse_reset);
        foreach (tbl[i]) begin
            drive(tbl[i][32:28], tbl[i][27:23], tbl[i][22], tbl[i][21], tbl[i][20], tbl[i][19],
                  tbl[i][18], tbl[i][17:13], tbl[i][12], tbl[i][11], tbl[i][10:6], tbl[i][5], tbl[i][4]);
            settle();
            checks++;
            if (dut_o() !== exp_o) begin
                errors++; $display("FAIL %s_outs[%0d] got=%b want=%b", name, i, dut_o(), exp_o);
            end
            checks++;
            if (hz.stall_cnt !== CW'(m_stall) || hz.flush_cnt !== CW'(m_flush)) begin
                errors++; $display("FAIL %s_cnt[%0d] got=%0d/%0d want=%0d/%0d", name, i,
                                   hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
            end
            tick();
            if (pulse_reset && i == 0) begin
                #2 reset_n = 1'b0;
                #1;
                extra_stalls = 0; m_stall = 0; m_flush = 0;
                checks++;
                if (dut_o() !== 9'b0 || hz.stall_cnt !== 0 || hz.flush_cnt !== 0) begin
                    errors++; $display("FAIL mid_stall_reset got=%b cnt=%0d/%0d want=0 0/0",
                                       dut_o(), hz.stall_cnt, hz.flush_cnt);
                end
                @(posedge clk); #1;
                reset_n = 1'b1;
            end
        end
    endtask

    task automatic test_load_use();
        logic [32:0] t [];
        t = new[2];
        t[0] = {5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0};
        t[1] = {5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 4'd0};
        run_table("load_use", t, 0);
    endtask

    task automatic test_load_branch();
        logic [32:0] t [];
        t = new[4];
        t[0] = {5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0};
        t[1] = {5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 4'd0};
        t[2] = {5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0};
        t[3] = {5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0};
        run_table("load_branch", t, 0);
    endtask

    task automatic test_zero_reg();
        logic [32:0] t [];
        t = new[2];
        t[0] = {5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0};
        t[1] = {5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 4'd0};
        run_table("zero_reg", t, 0);
    endtask

    task automatic test_reset_mid_stall();
        logic [32:0] t [];
        t = new[2];
        t[0] = {5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0};
        t[1] = {5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0};
        run_table("after_reset", t, 1);
    endtask

    task automatic test_saturation();
        logic [32:0] t [];
        t = new[MAXC + 5];
        foreach (t[i])
            t[i] = {5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0};
        t[0][4] = 1'b1;
        t[MAXC + 3][4] = 1'b1;
        run_table("saturate", t, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 29) == 0));
            settle();
            checks++;
            if (dut_o() !== exp_o) begin
                errors++; $display("FAIL random_outs[%0d] got=%b want=%b", i, dut_o(), exp_o);
            end
            checks++;
            if (hz.stall_cnt !== CW'(m_stall) || hz.flush_cnt !== CW'(m_flush)) begin
                errors++; $display("FAIL random_cnt[%0d] got=%0d/%0d want=%0d/%0d", i,
                                   hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_load_branch();
        test_zero_reg();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
